// File: rtl/md_hazard_ctrl_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | md_hazard_ctrl_if : controller <-> multiply/divide unit signal bundle  |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
interface md_hazard_ctrl_if;
  logic        md_start;
  logic [2:0]  md_op;
  logic        md_write;
  logic        md_addr;
  logic [31:0] md_d1;
  logic [31:0] md_d2;
  logic        md_busy;

  modport master (
    output md_start, md_op, md_write, md_addr, md_d1, md_d2,
    input  md_busy
  );

  modport slave (
    input  md_start, md_op, md_write, md_addr, md_d1, md_d2,
    output md_busy
  );
endinterface
`default_nettype wire

// File: rtl/md_hazard_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | md_hazard_ctrl : E-stage HI/LO unit issue, latency tracking, D stall  |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module md_hazard_ctrl #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CW       = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              e_valid,
  input  logic              e_md_start,
  input  logic [2:0]        e_mdop,
  input  logic              e_mt,
  input  logic              e_mt_sel,
  input  logic [31:0]       e_rs,
  input  logic [31:0]       e_rt,
  input  logic              d_md_use,
  md_hazard_ctrl_if.master  md,
  output logic              md_stall,
  output logic              sync_err,
  output logic [31:0]       stall_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  localparam logic [CW-1:0] C_MULT_LAT = CW'(MULT_LAT);
  localparam logic [CW-1:0] C_DIV_LAT  = CW'(DIV_LAT);
  localparam logic [CW-1:0] C_ONE      = CW'(1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sync_err_q, sync_err_d;
  logic [31:0]   stall_cnt_q, stall_cnt_d;

  logic w_valid_op;
  logic w_is_div;
  logic w_div_zero;
  logic w_issue;
  logic w_busy;

  assign w_valid_op = e_mdop inside {3'b000, 3'b001, 3'b010, 3'b011, 3'b101, 3'b110};
  assign w_is_div   = (e_mdop[2:1] == 2'b01);
  assign w_div_zero = w_is_div & (e_rt == 32'd0);
  assign w_busy     = (state_q != S_IDLE);
  assign w_issue    = e_valid & e_md_start & w_valid_op & ~w_div_zero & ~w_busy;

  assign md.md_start = w_issue;
  assign md.md_op    = e_mdop;
  // No state gating: a pending mthi/mtlo is held in D by the stall until the unit is idle.
  assign md.md_write = e_valid & e_mt;
  assign md.md_addr  = e_mt_sel;
  assign md.md_d1    = e_rs;
  assign md.md_d2    = e_rt;

  assign md_stall  = d_md_use & (w_issue | w_busy);
  assign sync_err  = sync_err_q;
  assign stall_cnt = stall_cnt_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sync_err_d  = sync_err_q | (w_busy != md.md_busy);
    stall_cnt_d = md_stall ? stall_cnt_q + 32'd1 : stall_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (w_issue) begin
          if (w_is_div) begin
            state_d = S_DIV;
            cnt_d   = C_DIV_LAT;
          end else begin
            state_d = S_MUL;
            cnt_d   = C_MULT_LAT;
          end
        end
      end
      S_MUL, S_DIV: begin
        // cnt counts the busy cycles left including the current one
        if (cnt_q == C_ONE) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - C_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      sync_err_q  <= 1'b0;
      stall_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sync_err_q  <= sync_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_md_hazard_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_md_hazard_ctrl : directed bench with cycle-level reference model   |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module tb_md_hazard_ctrl;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        e_valid = 1'b0;
  logic        e_md_start = 1'b0;
  logic [2:0]  e_mdop = 3'b000;
  logic        e_mt = 1'b0;
  logic        e_mt_sel = 1'b0;
  logic [31:0] e_rs = 32'd0;
  logic [31:0] e_rt = 32'd0;
  logic        d_md_use = 1'b0;
  logic        md_stall;
  logic        sync_err;
  logic [31:0] stall_cnt;

  md_hazard_ctrl_if mdif ();

  md_hazard_ctrl #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT), .CW(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .e_valid    (e_valid),
    .e_md_start (e_md_start),
    .e_mdop     (e_mdop),
    .e_mt       (e_mt),
    .e_mt_sel   (e_mt_sel),
    .e_rs       (e_rs),
    .e_rt       (e_rt),
    .d_md_use   (d_md_use),
    .md         (mdif.master),
    .md_stall   (md_stall),
    .sync_err   (sync_err),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the unit is busy during cycles cyc < free_at.
  longint cyc      = 0;
  longint free_at  = 0;
  bit     exp_sync = 1'b0;
  longint exp_cnt  = 0;

  // HI/LO unit model, reacting to the controller's outputs.
  longint      unit_free  = 0;
  bit          force_idle = 1'b0;
  logic [31:0] hi = 32'd0;
  logic [31:0] lo = 32'd0;
  logic        busy_w;

  assign busy_w       = ~force_idle & (cyc < unit_free);
  assign mdif.md_busy = busy_w;

  logic op_ok, op_div, exp_issue, exp_write, exp_stall;
  assign op_ok     = (e_mdop != 3'b100) && (e_mdop != 3'b111);
  assign op_div    = (e_mdop == 3'b010) || (e_mdop == 3'b011);
  assign exp_issue = e_valid & e_md_start & op_ok & ~(op_div & (e_rt == 32'd0)) & (cyc >= free_at);
  assign exp_write = e_valid & e_mt;
  assign exp_stall = d_md_use & (exp_issue | (cyc < free_at));

  function automatic logic [63:0] unit_calc(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [63:0] acc);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'b000:  return {32'd0, a} * {32'd0, b};
      3'b001:  return 64'(sa * sb);
      3'b010:  return {a % b, a / b};
      3'b011:  return {32'(sa % sb), 32'(sa / sb)};
      3'b101:  return acc + 64'(sa * sb);
      3'b110:  return acc - 64'(sa * sb);
      default: return acc;
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      free_at  <= cyc + 1;
      exp_sync <= 1'b0;
      exp_cnt  <= 0;
    end else begin
      if (exp_issue) free_at <= cyc + 1 + (op_div ? DIV_LAT : MULT_LAT);
      if ((cyc < free_at) != busy_w) exp_sync <= 1'b1;
      if (exp_stall) exp_cnt <= exp_cnt + 1;
    end
    cyc <= cyc + 1;
  end

  always @(posedge clk) begin
    if (reset) begin
      unit_free <= cyc + 1;
    end else begin
      if (mdif.md_start) begin
        unit_free <= cyc + 1 +
          (((mdif.md_op == 3'b010) || (mdif.md_op == 3'b011)) ? DIV_LAT : MULT_LAT);
        {hi, lo} <= unit_calc(mdif.md_op, mdif.md_d1, mdif.md_d2, {hi, lo});
      end
      if (mdif.md_write) begin
        if (mdif.md_addr) lo <= mdif.md_d1;
        else              hi <= mdif.md_d1;
      end
    end
  end

  int tb_stalls = 0;
  int tb_starts = 0;

  always @(negedge clk) begin
    if (md_stall) tb_stalls <= tb_stalls + 1;
    if (mdif.md_start) tb_starts <= tb_starts + 1;
    if (chk_en) begin
      chk("md_start",  mdif.md_start, exp_issue);
      chk("md_write",  mdif.md_write, exp_write);
      chk("md_stall",  md_stall,      exp_stall);
      chk("md_op",     mdif.md_op,    e_mdop);
      chk("md_addr",   mdif.md_addr,  e_mt_sel);
      chk("md_d1",     mdif.md_d1,    e_rs);
      chk("md_d2",     mdif.md_d2,    e_rt);
      chk("sync_err",  sync_err,      exp_sync);
      chk("stall_cnt", stall_cnt,     64'(exp_cnt[31:0]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_e();
    e_valid    = 1'b0;
    e_md_start = 1'b0;
    e_mt       = 1'b0;
  endtask

  task automatic do_reset();
    idle_e();
    d_md_use = 1'b0;
    reset    = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic issue_md(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
    e_valid    = 1'b1;
    e_md_start = 1'b1;
    e_mt       = 1'b0;
    e_mdop     = op;
    e_rs       = rs;
    e_rt       = rt;
  endtask

  task automatic wait_release();
    for (int i = 0; i < 40 && md_stall; i++) tick();
    if (md_stall) chk("release_timeout", md_stall, 1'b0);
  endtask

  int s_st, s_go;
  logic [31:0] hi0, lo0;

  initial begin
    tick();
    reset  = 1'b0;
    chk_en = 1'b1;
    chk("rst_sync_err",  sync_err,  1'b0);
    chk("rst_stall_cnt", stall_cnt, 32'd0);
    chk("rst_md_stall",  md_stall,  1'b0);
    chk("rst_md_start",  mdif.md_start, 1'b0);

    // mult 3*7 with mflo waiting in D
    s_st = tb_stalls; s_go = tb_starts;
    issue_md(3'b001, 32'd3, 32'd7);
    d_md_use = 1'b1;
    tick();
    idle_e();
    wait_release();
    chk("mult_stall_cycles", 64'(tb_stalls - s_st), 64'd6);
    chk("mult_starts",       64'(tb_starts - s_go), 64'd1);
    chk("mult_stall_cnt",    stall_cnt, 32'd6);
    chk("mult_lo",           lo, 32'd21);
    d_md_use = 1'b0;
    tick();

    // signed div 100/7 with mfhi waiting in D
    do_reset();
    s_st = tb_stalls;
    issue_md(3'b011, 32'd100, 32'd7);
    d_md_use = 1'b1;
    tick();
    idle_e();
    wait_release();
    chk("div_stall_cycles", 64'(tb_stalls - s_st), 64'd11);
    chk("div_hi",           hi, 32'd2);
    chk("div_lo",           lo, 32'd14);
    chk("div_sync_err",     sync_err, 1'b0);
    d_md_use = 1'b0;
    tick();

    // divu by zero: no issue, no stall, HI/LO untouched
    hi0 = hi; lo0 = lo;
    issue_md(3'b010, 32'd55, 32'd0);
    d_md_use = 1'b1;
    #1;
    chk("div0_start", mdif.md_start, 1'b0);
    chk("div0_stall", md_stall, 1'b0);
    tick();
    idle_e();
    #1;
    chk("div0_stall_next", md_stall, 1'b0);
    tick();
    chk("div0_hilo", {hi, lo}, {hi0, lo0});

    // mthi with idle unit, then mfhi
    e_valid  = 1'b1;
    e_mt     = 1'b1;
    e_mt_sel = 1'b0;
    e_rs     = 32'hDEADBEEF;
    d_md_use = 1'b1;
    #1;
    chk("mthi_write", mdif.md_write, 1'b1);
    chk("mthi_addr",  mdif.md_addr,  1'b0);
    tick();
    idle_e();
    #1;
    chk("mfhi_value", hi, 32'hDEADBEEF);
    chk("mfhi_stall", md_stall, 1'b0);
    d_md_use = 1'b0;
    tick();

    // e_valid low and invalid op codes must not issue
    issue_md(3'b001, 32'd2, 32'd2);
    e_valid  = 1'b0;
    e_mt     = 1'b1;
    d_md_use = 1'b1;
    #1;
    chk("bubble_start", mdif.md_start, 1'b0);
    chk("bubble_write", mdif.md_write, 1'b0);
    chk("bubble_stall", md_stall, 1'b0);
    tick();
    issue_md(3'b100, 32'd2, 32'd2);
    #1;
    chk("badop_start", mdif.md_start, 1'b0);
    tick();
    issue_md(3'b111, 32'd2, 32'd2);
    #1;
    chk("badop7_start", mdif.md_start, 1'b0);
    tick();
    idle_e();
    d_md_use = 1'b0;
    tick();

    // back-to-back: the MD op held in D issues the cycle it is released
    do_reset();
    issue_md(3'b001, 32'd4, 32'd4);
    d_md_use = 1'b1;
    tick();
    idle_e();
    wait_release();
    issue_md(3'b000, 32'd5, 32'd6);
    d_md_use = 1'b0;
    #1;
    chk("b2b_start", mdif.md_start, 1'b1);
    tick();
    idle_e();
    #1;
    chk("b2b_lo", lo, 32'd30);
    tick();

    // madd then msub accumulate on HI/LO: 30 + 2*3 - 1*4 = 32
    wait_release();
    for (int i = 0; i < 8; i++) tick();
    issue_md(3'b101, 32'd2, 32'd3);
    tick();
    idle_e();
    for (int i = 0; i < 6; i++) tick();
    issue_md(3'b110, 32'd1, 32'd4);
    tick();
    idle_e();
    #1;
    chk("madd_msub_lo", lo, 32'd32);
    for (int i = 0; i < 6; i++) tick();

    // reset in the middle of a multu busy window
    do_reset();
    issue_md(3'b000, 32'd2, 32'd3);
    d_md_use = 1'b1;
    tick();
    idle_e();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("rstmid_stall",     md_stall,  1'b0);
    chk("rstmid_stall_cnt", stall_cnt, 32'd0);
    chk("rstmid_sync_err",  sync_err,  1'b0);
    d_md_use = 1'b0;
    tick();

    // unit busy disagreeing with controller state
    do_reset();
    issue_md(3'b001, 32'd1, 32'd1);
    tick();
    idle_e();
    force_idle = 1'b1;
    tick();
    chk("sync_set", sync_err, 1'b1);
    force_idle = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("sync_held", sync_err, 1'b1);
    do_reset();
    #1;
    chk("sync_clear", sync_err, 1'b0);
    tick();

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
